addr_reg_file_p: RTL and testbench
==================================

# addr_reg_file_p

Parametrised address register file holding NUM_REGS address registers (default three: PC, SP, AR) of WIDTH bits, with per-register increment, decrement, load and clear, plus two independent combinational read ports. Sits between the ALU-system data bus and the memory address mux. It adds a configurable step size, sticky per-register wrap flags and an optional hardware stack-bounds guard on the SP register.

## Interface
- NUM_REGS, 3: number of address registers, at least 2.
- WIDTH, 16: register and bus width.
- STEP, 1: increment/decrement amount, in the range 1 to 2^WIDTH-1.
- RST_VAL, 0: reset value of every register.
- SP_IDX, 1: index of the stack pointer register.
- STACK_LO, 0 and STACK_HI, 2^WIDTH-1: inclusive SP bounds, used only when the guard is compiled in.
- SEL_W, $clog2(NUM_REGS): derived read-select width.

- Clock  in  1  rising-edge clock.
- ResetN  in  1  asynchronous, active-low reset.
- I  in  WIDTH  load data.
- RegSel  in  NUM_REGS  per-register enable. Bit k selects register k; several bits may be set at once.
- FunSel  in  2  operation:
  - 00 decrement by STEP
  - 01 increment by STEP
  - 10 load I
  - 11 clear to 0
- FlagClr  in  1  synchronous clear of WrapFlags and StackErr.
- OutCSel  in  SEL_W  read select for port C.
- OutDSel  in  SEL_W  read select for port D.
- OutC  out  WIDTH  register[OutCSel].
- OutD  out  WIDTH  register[OutDSel].
- WrapFlags  out  NUM_REGS  sticky per-register carry/borrow flags.
- StackErr  out  1  sticky SP bounds violation.

## Operation
- Reset (ResetN=0) applies immediately, with no wait for a clock edge:
  - every register goes to RST_VAL;
  - WrapFlags and StackErr go to 0.
- Arithmetic is modulo 2^WIDTH.
- On each rising edge, every register with RegSel[k]=1 applies FunSel. Registers with RegSel[k]=0 hold.
- Wrap detection:
  - increment with carry-out sets WrapFlags[k];
  - decrement with borrow sets WrapFlags[k];
  - load and clear never set it.
- Read ports:
  - an in-range select returns that register;
  - a select of NUM_REGS or above returns register NUM_REGS-1.
  - Both ports may select the same register.
- FlagClr=1 clears the flags at the edge. If a wrap or stack error occurs in the same cycle, the set wins.
- Stack guard (ARF_STACK_GUARD_EN only):
  - increment of SP where SP+STEP > STACK_HI or the increment wraps: SP holds, StackErr is set, WrapFlags[SP_IDX] is not set;
  - decrement where SP-STEP < STACK_LO or the decrement wraps: same behaviour.
  - Loads and clears are never checked.
  - Other registers are unaffected.

## Timing
- Write latency is 1 cycle. A new value is visible on OutC/OutD just after the edge; there is no same-cycle bypass of I.
- Read latency is 0, since the read ports are combinational.
- Flags update on the same edge as the register that caused them.
- ResetN deasserted mid-operation: the first edge after release performs a normal operation from RST_VAL.

## Configuration
- ARF_STACK_GUARD_EN:
  - defined: SP bounds checking as described under Operation, and StackErr is live.
  - undefined: SP behaves like any other register and wraps, StackErr is tied to 0, and STACK_LO/STACK_HI are ignored.

## Structure
- Package arf_pkg holds:
  - an enum for FunSel (ARF_DEC, ARF_INC, ARF_LOAD, ARF_CLR);
  - a function computing the read-select width from NUM_REGS.
- Sub-module addr_reg handles one register. It has WIDTH, STEP and RST_VAL parameters, Clock, ResetN, E, FunSel, I, Q, and a one-cycle pulse output Wrap.
- The top level contains:
  - a generate loop over addr_reg instances;
  - the SP guard logic on the SP_IDX enable/result path;
  - the flag registers;
  - the two read muxes.

## Test plan
- Reset, then OutCSel=0 and OutDSel=2 -> OutC=OutD=0x0000, WrapFlags=000, StackErr=0.
- Load 0x1234 into all registers (RegSel=111, FunSel=10), then increment PC only -> PC=0x1235, SP=AR=0x1234.
- Load PC=0xFFFF, then increment -> PC=0x0000 and WrapFlags[0]=1. Assert FlagClr while decrementing PC from 0 in the same cycle -> WrapFlags[0] stays 1.
- With STEP=2, load AR=0x0001, then decrement -> AR=0xFFFF and WrapFlags[2]=1.
- Guard defined, STACK_HI=0x00FF: load SP=0x00FF, then increment -> SP=0x00FF, StackErr=1. Assert FlagClr -> StackErr=0.
- NUM_REGS=3, OutCSel=3 -> OutC equals AR. Assert ResetN mid-cycle -> all outputs go to 0 with no clock edge.

Source files
------------

// File: rtl/arf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arf_pkg : shared FunSel encoding and select-width helper           |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package arf_pkg;

  typedef enum logic [1:0] {
    ARF_DEC  = 2'b00,
    ARF_INC  = 2'b01,
    ARF_LOAD = 2'b10,
    ARF_CLR  = 2'b11
  } arf_fun_e;

  function automatic int arf_sel_w(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addr_reg : one address register, dec/inc/load/clear, wrap pulse    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module addr_reg
  import arf_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] STEP    = WIDTH'(1),
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             E,
  input  logic [1:0]       FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             Wrap
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // Wrap is combinational so the owner's sticky flag lands on the same edge.
  always_comb begin
    sum  = {1'b0, q_q} + {1'b0, STEP};
    diff = {1'b0, q_q} - {1'b0, STEP};
    q_d  = q_q;
    Wrap = 1'b0;
    if (E) begin
      case (FunSel)
        ARF_DEC: begin
          q_d  = diff[WIDTH-1:0];
          Wrap = diff[WIDTH];
        end
        ARF_INC: begin
          q_d  = sum[WIDTH-1:0];
          Wrap = sum[WIDTH];
        end
        ARF_LOAD: q_d = I;
        default:  q_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule
`default_nettype wire

// File: rtl/addr_reg_file_p.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addr_reg_file_p : address register file, two read ports, wrap flags|
// | Optional SP bounds guard: ARF_STACK_GUARD_EN            Rev 1.0    |
// +--------------------------------------------------------------------+
module addr_reg_file_p
  import arf_pkg::*;
#(
  parameter int               NUM_REGS = 3,
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] STEP     = WIDTH'(1),
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               SP_IDX   = 1,
  parameter logic [WIDTH-1:0] STACK_LO = '0,
  parameter logic [WIDTH-1:0] STACK_HI = '1,
  parameter int               SEL_W    = arf_sel_w(NUM_REGS)
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic [WIDTH-1:0]    I,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [1:0]          FunSel,
  input  logic                FlagClr,
  input  logic [SEL_W-1:0]    OutCSel,
  input  logic [SEL_W-1:0]    OutDSel,
  output logic [WIDTH-1:0]    OutC,
  output logic [WIDTH-1:0]    OutD,
  output logic [NUM_REGS-1:0] WrapFlags,
  output logic                StackErr
);

  logic [NUM_REGS-1:0][WIDTH-1:0] reg_q;
  logic [NUM_REGS-1:0]            reg_en;
  logic [NUM_REGS-1:0]            wrap_pulse;
  logic                           stack_err_set;

  logic [NUM_REGS-1:0] wrap_flags_q;
  logic [NUM_REGS-1:0] wrap_flags_d;
  logic                stack_err_q;
  logic                stack_err_d;

`ifdef ARF_STACK_GUARD_EN
  logic [WIDTH:0] sp_sum;
  logic [WIDTH:0] sp_diff;
  logic           sp_block;

  // A blocked SP update suppresses the enable, so the register never wraps.
  always_comb begin
    sp_sum   = {1'b0, reg_q[SP_IDX]} + {1'b0, STEP};
    sp_diff  = {1'b0, reg_q[SP_IDX]} - {1'b0, STEP};
    sp_block = 1'b0;
    if (RegSel[SP_IDX]) begin
      if (FunSel == ARF_INC) begin
        sp_block = sp_sum[WIDTH] || (sp_sum[WIDTH-1:0] > STACK_HI);
      end else if (FunSel == ARF_DEC) begin
        sp_block = sp_diff[WIDTH] || (sp_diff[WIDTH-1:0] < STACK_LO);
      end
    end
    reg_en         = RegSel;
    reg_en[SP_IDX] = RegSel[SP_IDX] & ~sp_block;
  end

  assign stack_err_set = sp_block;
`else
  logic unused_stack_cfg;
  assign unused_stack_cfg = ^{STACK_LO, STACK_HI};
  assign reg_en           = RegSel;
  assign stack_err_set    = 1'b0;
`endif

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    addr_reg #(
      .WIDTH   (WIDTH),
      .STEP    (STEP),
      .RST_VAL (RST_VAL)
    ) u_reg (
      .Clock  (Clock),
      .ResetN (ResetN),
      .E      (reg_en[k]),
      .FunSel (FunSel),
      .I      (I),
      .Q      (reg_q[k]),
      .Wrap   (wrap_pulse[k])
    );
  end

  // Set beats clear when both happen on the same edge.
  always_comb begin
    wrap_flags_d = (FlagClr ? '0 : wrap_flags_q) | wrap_pulse;
    stack_err_d  = (stack_err_q & ~FlagClr) | stack_err_set;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wrap_flags_q <= '0;
      stack_err_q  <= 1'b0;
    end else begin
      wrap_flags_q <= wrap_flags_d;
      stack_err_q  <= stack_err_d;
    end
  end

  // Out-of-range selects fall through to the last register.
  always_comb begin
    OutC = reg_q[NUM_REGS-1];
    OutD = reg_q[NUM_REGS-1];
    for (int k = 0; k < NUM_REGS; k++) begin
      if (OutCSel == SEL_W'(k)) OutC = reg_q[k];
      if (OutDSel == SEL_W'(k)) OutD = reg_q[k];
    end
  end

  assign WrapFlags = wrap_flags_q;
  assign StackErr  = stack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_addr_reg_file_p.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_addr_reg_file_p : directed vectors with a scoreboard monitor    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_addr_reg_file_p;

`ifdef ARF_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic [2:0]  reg_sel = '0;
  logic [1:0]  fun_sel = '0;
  logic        flag_clr = 1'b0;
  logic [1:0]  out_c_sel = 2'd0;
  logic [1:0]  out_d_sel = 2'd2;
  logic [15:0] out_c;
  logic [15:0] out_d;
  logic [2:0]  wrap_flags;
  logic        stack_err;

  typedef struct {
    string       name;
    logic [15:0] c;
    logic [15:0] d;
    logic [2:0]  wf;
    logic        se;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  addr_reg_file_p #(
    .NUM_REGS (3),
    .WIDTH    (16),
    .STEP     (16'd2),
    .RST_VAL  (16'h0000),
    .SP_IDX   (1),
    .STACK_LO (16'h0010),
    .STACK_HI (16'h00FF)
  ) dut (
    .Clock     (clk),
    .ResetN    (rst_n),
    .I         (din),
    .RegSel    (reg_sel),
    .FunSel    (fun_sel),
    .FlagClr   (flag_clr),
    .OutCSel   (out_c_sel),
    .OutDSel   (out_d_sel),
    .OutC      (out_c),
    .OutD      (out_d),
    .WrapFlags (wrap_flags),
    .StackErr  (stack_err)
  );

  task automatic cmp(input string name, input string what, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", name, what, act, exp);
    end
  endtask

  // Outputs are stable mid-cycle; compare one queued expectation per falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      cmp(mon_e.name, "OutC", out_c, mon_e.c);
      cmp(mon_e.name, "OutD", out_d, mon_e.d);
      cmp(mon_e.name, "WrapFlags", {13'd0, wrap_flags}, {13'd0, mon_e.wf});
      cmp(mon_e.name, "StackErr", {15'd0, stack_err}, {15'd0, mon_e.se});
    end
  end

  task automatic step(input string name, input logic [2:0] rs, input logic [1:0] fs,
                      input logic [15:0] di, input logic clr, input logic [1:0] cs,
                      input logic [1:0] ds, input logic [15:0] ec, input logic [15:0] ed,
                      input logic [2:0] ewf, input logic ese);
    @(negedge clk);
    #1;
    reg_sel   = rs;
    fun_sel   = fs;
    din       = di;
    flag_clr  = clr;
    out_c_sel = cs;
    out_d_sel = ds;
    @(posedge clk);
    #1;
    reg_sel  = '0;
    flag_clr = 1'b0;
    sb_q.push_back('{name, ec, ed, ewf, ese});
  endtask

  initial begin
    #1;
    sb_q.push_back('{"reset", 16'h0000, 16'h0000, 3'b000, 1'b0});
    #11;
    rst_n = 1'b1;

    step("load_all",  3'b111, 2'b10, 16'h1234, 0, 2'd0, 2'd1, 16'h1234, 16'h1234, 3'b000, 0);
    step("inc_pc",    3'b001, 2'b01, 16'h0000, 0, 2'd0, 2'd2, 16'h1236, 16'h1234, 3'b000, 0);
    step("inc_sp_hi", 3'b010, 2'b01, 16'h0000, 0, 2'd1, 2'd2,
         GUARD ? 16'h1234 : 16'h1236, 16'h1234, 3'b000, GUARD);
    step("clr_serr",  3'b000, 2'b00, 16'h0000, 1, 2'd1, 2'd2,
         GUARD ? 16'h1234 : 16'h1236, 16'h1234, 3'b000, 0);
    step("load_pc",   3'b001, 2'b10, 16'hFFFF, 0, 2'd0, 2'd3, 16'hFFFF, 16'h1234, 3'b000, 0);
    step("inc_wrap",  3'b001, 2'b01, 16'h0000, 0, 2'd0, 2'd3, 16'h0001, 16'h1234, 3'b001, 0);
    step("dec_clr",   3'b001, 2'b00, 16'h0000, 1, 2'd0, 2'd3, 16'hFFFF, 16'h1234, 3'b001, 0);
    step("clr_wrap",  3'b000, 2'b00, 16'h0000, 1, 2'd0, 2'd3, 16'hFFFF, 16'h1234, 3'b000, 0);
    step("load_ar",   3'b100, 2'b10, 16'h0001, 0, 2'd2, 2'd0, 16'h0001, 16'hFFFF, 3'b000, 0);
    step("dec_ar",    3'b100, 2'b00, 16'h0000, 0, 2'd2, 2'd0, 16'hFFFF, 16'hFFFF, 3'b100, 0);
    step("dec_pc_ar", 3'b101, 2'b00, 16'h0000, 0, 2'd0, 2'd3, 16'hFFFD, 16'hFFFD, 3'b100, 0);
    step("load_sp",   3'b010, 2'b10, 16'h00FF, 0, 2'd1, 2'd1, 16'h00FF, 16'h00FF, 3'b100, 0);
    step("inc_sp",    3'b010, 2'b01, 16'h0000, 0, 2'd1, 2'd1,
         GUARD ? 16'h00FF : 16'h0101, GUARD ? 16'h00FF : 16'h0101, 3'b100, GUARD);
    step("clr_all",   3'b000, 2'b00, 16'h0000, 1, 2'd1, 2'd1,
         GUARD ? 16'h00FF : 16'h0101, GUARD ? 16'h00FF : 16'h0101, 3'b000, 0);
    step("load_sp2",  3'b010, 2'b10, 16'h0011, 0, 2'd1, 2'd1, 16'h0011, 16'h0011, 3'b000, 0);
    step("dec_sp_lo", 3'b010, 2'b00, 16'h0000, 0, 2'd1, 2'd1,
         GUARD ? 16'h0011 : 16'h000F, GUARD ? 16'h0011 : 16'h000F, 3'b000, GUARD);
    step("dec_sp_cl", 3'b010, 2'b00, 16'h0000, 1, 2'd1, 2'd1,
         GUARD ? 16'h0011 : 16'h000D, GUARD ? 16'h0011 : 16'h000D, 3'b000, GUARD);
    step("clr_serr2", 3'b000, 2'b00, 16'h0000, 1, 2'd1, 2'd1,
         GUARD ? 16'h0011 : 16'h000D, GUARD ? 16'h0011 : 16'h000D, 3'b000, 0);
    step("clear_all", 3'b111, 2'b11, 16'h5555, 0, 2'd0, 2'd2, 16'h0000, 16'h0000, 3'b000, 0);
    step("dec_sp_0",  3'b010, 2'b00, 16'h0000, 0, 2'd1, 2'd0,
         GUARD ? 16'h0000 : 16'hFFFE, 16'h0000, GUARD ? 3'b000 : 3'b010, GUARD);
    step("load_abcd", 3'b111, 2'b10, 16'hABCD, 0, 2'd0, 2'd2,
         16'hABCD, 16'hABCD, GUARD ? 3'b000 : 3'b010, GUARD);

    // Reset asserted between edges must clear outputs before any clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.push_back('{"async_rst", 16'h0000, 16'h0000, 3'b000, 1'b0});
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    step("post_rst",  3'b001, 2'b01, 16'h0000, 0, 2'd0, 2'd2, 16'h0002, 16'h0000, 3'b000, 0);

    for (int n = 0; n < 20 && sb_q.size() > 0; n++) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
